// File: rtl/matrix_transpose_stream_pkg.sv
// Shared types and helpers for the streaming matrix transpose.
// Latency: n/a (package only).
// Backpressure: n/a. MATRIX_TRANSPOSE_PINGPONG_EN selects two RAM banks instead of one.
package matrix_transpose_stream_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

`ifdef MATRIX_TRANSPOSE_PINGPONG_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif

  // Address width for n elements, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_transpose_stream_if.sv
// Input and output element streams of the transpose block, valid/ready on both sides.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready; slave is the transpose, master is the surrounding datapath.
interface matrix_transpose_stream_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matrix_transpose_stream_tp_sdp_ram.sv
// Simple dual-port RAM holding the matrix bank(s): one write port, one registered read port.
// Latency: rdata valid one cycle after re.
// Backpressure: none; the caller only reads when it has room for the result.
module matrix_transpose_stream_tp_sdp_ram #(
  parameter int DATA_W = 4,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Depth rounded up to a power of two so every address pattern decodes cleanly.
  logic [DATA_W-1:0] mem [2**AW];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming ROWSxCOLS transpose: row-major in, column-wise out; MATRIX_TRANSPOSE_PINGPONG_EN adds a second bank.
// Latency: out_valid two cycles after the last input of a matrix is accepted (RAM read + output register).
// Backpressure: in_ready low while no bank can be written; two-entry output skid keeps 1 beat/cycle under out_ready.
module matrix_transpose_stream
  import matrix_transpose_stream_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 2,
  parameter int DATA_W = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  matrix_transpose_stream_if.slave io
);

  localparam int N   = ROWS * COLS;
  localparam int AW  = clog2_min1(N);
  localparam int RAW = (NBANKS > 1) ? AW + 1 : AW;

  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
  localparam logic [AW-1:0] LAST_COL  = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_STEP = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] COLS_W    = AW'(COLS);

  bank_state_e st [2];

  logic [AW-1:0] wr_idx;
  logic          wr_bank;
  logic          wr_acc, wr_done;

  logic [AW-1:0] rd_base, rd_step;
  logic          rd_bank, rel_bank, rd_busy;
  logic          rd_issue, rd_end, col_end, room;
  logic          rd_pend, rd_pend_last;

  logic [RAW-1:0]    waddr, raddr;
  logic [DATA_W-1:0] ram_q;

  logic [1:0]        q_cnt;
  logic [DATA_W-1:0] q0_dat, q1_dat;
  logic              q0_last, q1_last;
  logic              pop, rel;

  assign io.in_ready = (st[wr_bank] == EMPTY) || (st[wr_bank] == FILLING);
  assign wr_acc      = io.in_valid && io.in_ready;
  assign wr_done     = wr_acc && (wr_idx == LAST_IDX);

  // Read address walks down a column (step += COLS) then moves to the next column (base += 1).
  assign col_end  = (rd_step == LAST_STEP);
  assign rd_end   = col_end && (rd_base == LAST_COL);
  // Issue only if the result is guaranteed a skid slot, counting the read already in flight.
  assign room     = ({1'b0, q_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop});
  assign rd_issue = (rd_busy || (st[rd_bank] == FULL)) && room;

  assign pop = io.out_valid && io.out_ready;
  assign rel = pop && io.out_last;

`ifdef MATRIX_TRANSPOSE_PINGPONG_EN
  assign waddr = {wr_bank, wr_idx};
  assign raddr = {rd_bank, AW'(rd_base + rd_step)};
`else
  assign waddr = wr_idx;
  assign raddr = AW'(rd_base + rd_step);
`endif

  matrix_transpose_stream_tp_sdp_ram #(
    .DATA_W (DATA_W),
    .AW     (RAW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (waddr),
    .wdata (io.in_data),
    .re    (rd_issue),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Write/read element counters and bank pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      rd_base  <= '0;
      rd_step  <= '0;
      rd_bank  <= 1'b0;
      rel_bank <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_idx <= wr_done ? '0 : wr_idx + 1'b1;
`ifdef MATRIX_TRANSPOSE_PINGPONG_EN
        if (wr_done) wr_bank <= ~wr_bank;
`endif
      end
      if (rd_issue) begin
        rd_busy <= !rd_end;
        if (col_end) begin
          rd_step <= '0;
          rd_base <= rd_end ? '0 : rd_base + 1'b1;
        end else begin
          rd_step <= rd_step + COLS_W;
        end
`ifdef MATRIX_TRANSPOSE_PINGPONG_EN
        if (rd_end) rd_bank <= ~rd_bank;
`endif
      end
`ifdef MATRIX_TRANSPOSE_PINGPONG_EN
      if (rel) rel_bank <= ~rel_bank;
`endif
    end
  end

  // Bank FSMs: each event needs a distinct state, so write, read and release never collide on one bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) st[b] <= EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) begin
        case (st[b])
          EMPTY:    if (wr_acc && (wr_bank == 1'(b))) st[b] <= wr_done ? FULL : FILLING;
          FILLING:  if (wr_done && (wr_bank == 1'(b))) st[b] <= FULL;
          FULL:     if (rd_issue && (rd_bank == 1'(b))) st[b] <= DRAINING;
          DRAINING: if (rel && (rel_bank == 1'(b))) st[b] <= EMPTY;
          default:  st[b] <= EMPTY;
        endcase
      end
    end
  end

  // Marks the cycle in which RAM read data is valid, with its end-of-matrix flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && rd_end;
    end
  end

  // Two-entry output skid; q0 drives the port, so data holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_cnt   <= 2'd0;
      q0_dat  <= '0;
      q1_dat  <= '0;
      q0_last <= 1'b0;
      q1_last <= 1'b0;
    end else begin
      case ({rd_pend, pop})
        2'b01: begin
          q0_dat  <= q1_dat;
          q0_last <= q1_last;
          q_cnt   <= q_cnt - 1'b1;
        end
        2'b10: begin
          if (q_cnt == 2'd0) begin
            q0_dat  <= ram_q;
            q0_last <= rd_pend_last;
          end else begin
            q1_dat  <= ram_q;
            q1_last <= rd_pend_last;
          end
          q_cnt <= q_cnt + 1'b1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q0_dat  <= ram_q;
            q0_last <= rd_pend_last;
          end else begin
            q0_dat  <= q1_dat;
            q0_last <= q1_last;
            q1_dat  <= ram_q;
            q1_last <= rd_pend_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.out_valid = (q_cnt != 2'd0);
  assign io.out_data  = q0_dat;
  assign io.out_last  = q0_last && io.out_valid;

endmodule

// File: tb/tb_matrix_transpose_stream.sv
module tb_matrix_transpose_stream;

`ifdef MATRIX_TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  matrix_transpose_stream_if #(.DATA_W(4)) ifa ();
  matrix_transpose_stream_if #(.DATA_W(8)) ifb ();

  matrix_transpose_stream #(.ROWS(3), .COLS(2), .DATA_W(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .io(ifa)
  );
  matrix_transpose_stream #(.ROWS(4), .COLS(4), .DATA_W(8)) dut_b (
    .clk(clk), .rst_n(rst_b), .io(ifb)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: pending input elements, current partial matrix, expected output stream.
  logic [7:0] src_q[$];
  logic [7:0] mbuf[$];
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  int         mats_in, mats_out;
  bit         lat_pend;
  int         lat_t;
  bit         stall_pend;
  logic [7:0] stall_dat;
  logic       stall_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    src_q.delete(); mbuf.delete(); exp_q.delete(); exp_last_q.delete();
    mats_in = 0; mats_out = 0; lat_pend = 0; stall_pend = 0;
  endtask

  function automatic int nrows(input int d); return (d == 0) ? 3 : 4; endfunction
  function automatic int ncols(input int d); return (d == 0) ? 2 : 4; endfunction

  // One clock of DUT d; the other DUT is held idle.
  task automatic cycle(input int d, input bit iv_req, input bit ordy);
    logic iv, ir, ov, ol;
    logic [7:0] id, od;
    bit e_last;
    int R, C;
    R = nrows(d); C = ncols(d);
    iv = iv_req && (src_q.size() != 0);
    id = iv ? src_q[0] : 8'h00;
    ifa.in_valid = (d == 0) && iv; ifa.in_data = id[3:0]; ifa.out_ready = (d == 0) ? ordy : 1'b1;
    ifb.in_valid = (d == 1) && iv; ifb.in_data = id;      ifb.out_ready = (d == 1) ? ordy : 1'b1;
    ir = (d == 0) ? ifa.in_ready  : ifb.in_ready;
    ov = (d == 0) ? ifa.out_valid : ifb.out_valid;
    ol = (d == 0) ? ifa.out_last  : ifb.out_last;
    od = (d == 0) ? {4'h0, ifa.out_data} : ifb.out_data;

    chk("in_ready", ir, ((mats_in - mats_out) < NB) ? 1 : 0);
    chk("spurious_valid", ov && (exp_q.size() == 0), 0);
    if (stall_pend) begin
      chk("stall_valid", ov, 1);
      chk("stall_data", od, stall_dat);
      chk("stall_last", ol, stall_last);
    end
    if (lat_pend && ov) begin
      chk("latency", cyc - lat_t, 2);
      lat_pend = 0;
    end
    if (ov && ordy && exp_q.size() != 0) begin
      chk("out_data", od, exp_q.pop_front());
      e_last = exp_last_q.pop_front();
      chk("out_last", ol, e_last);
      if (e_last) mats_out++;
    end
    stall_pend = ov && !ordy;
    stall_dat  = od;
    stall_last = ol;
    if (iv && ir) begin
      mbuf.push_back(src_q.pop_front());
      if (mbuf.size() == R * C) begin
        if (exp_q.size() == 0) begin
          lat_pend = 1;
          lat_t    = cyc + 1;   // first slot that sees the accept
        end
        // B[c][r] = A[r][c], emitted row-major over B.
        for (int c = 0; c < C; c++)
          for (int r = 0; r < R; r++) begin
            exp_q.push_back(mbuf[r * C + c]);
            exp_last_q.push_back((c == C - 1) && (r == R - 1));
          end
        mbuf.delete();
        mats_in++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random.
  task automatic run(input int d, input int vpct, input int rmode, input int budget);
    int k;
    bit ordy, iv;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      case (rmode)
        0:       ordy = 1'b1;
        1:       ordy = (k % 4 == 0) || (k % 4 == 3);
        default: ordy = ($urandom_range(0, 99) < 65);
      endcase
      iv = (vpct >= 100) || ($urandom_range(0, 99) < vpct);
      cycle(d, iv, ordy);
      k++;
    end
    chk("drained", src_q.size() + exp_q.size(), 0);
  endtask

  task automatic load_seq(input int first, input int count);
    for (int i = 0; i < count; i++) src_q.push_back(8'(first + i));
  endtask

  task automatic load_rand(input int count, input int maxv);
    for (int i = 0; i < count; i++) src_q.push_back(8'($urandom_range(0, maxv)));
  endtask

  task automatic do_reset(input int d);
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b1; ifb.in_data = '0;
    if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
    repeat (2) @(negedge clk);
    if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    model_clear();
    chk("rst_in_ready",  (d == 0) ? ifa.in_ready  : ifb.in_ready, 1);
    chk("rst_out_valid", (d == 0) ? ifa.out_valid : ifb.out_valid, 0);
    chk("rst_out_last",  (d == 0) ? ifa.out_last  : ifb.out_last, 0);
    chk("rst_out_data",  (d == 0) ? {4'h0, ifa.out_data} : ifb.out_data, 0);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset(0);
    do_reset(1);

    // 3x2: 1..6 straight through.
    load_seq(1, 6);   run(0, 100, 0, 200);
    // Output stalls with ready pattern 1,0,0,1.
    load_seq(1, 6);   run(0, 100, 1, 200);
    // Two back-to-back matrices with in_valid held high.
    load_seq(1, 12);  run(0, 100, 0, 300);
    // Reset after four inputs, then a fresh matrix 9..14.
    load_seq(1, 4);   run(0, 100, 0, 50);
    do_reset(0);
    load_seq(9, 6);   run(0, 100, 0, 200);
    // 4x4x8: 0..15.
    load_seq(0, 16);  run(1, 100, 0, 300);
    // Randomized traffic on both shapes.
    load_rand(30, 15); run(0, 60, 2, 2000);
    load_rand(48, 255); run(1, 70, 2, 3000);
    load_rand(24, 15); run(0, 100, 2, 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
